// File: rtl/reg_file_pkg.sv
// Shared types and default geometry for the N-port register file slice.
package reg_file_pkg;

    localparam int unsigned DEF_WORD_WIDTH    = 32;
    localparam int unsigned DEF_ADDRESS_WIDTH = 5;
    localparam int unsigned DEF_READ_PORTS    = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    // Entry 0 is protected from writes when the hardwired-zero option is on.
    function automatic logic write_allowed(input logic wen, input logic addr_is_zero,
                                           input logic zero_reg);
        return wen && !(zero_reg && addr_is_zero);
    endfunction

endpackage

// File: rtl/reg_file_nport_if.sv
// Decode/writeback side bus of the register file: read addresses, write port, read data, ready.
interface reg_file_nport_if #(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned READ_PORTS    = 2
);
    logic [READ_PORTS*ADDRESS_WIDTH-1:0] RA;
    logic [ADDRESS_WIDTH-1:0]            WA3;
    logic [WORD_WIDTH-1:0]               WD3;
    logic                                WEN;
    logic [READ_PORTS*WORD_WIDTH-1:0]    RD;
    logic                                READY;

    modport master (
        output RA, WA3, WD3, WEN,
        input  RD, READY
    );

    modport slave (
        input  RA, WA3, WD3, WEN,
        output RD, READY
    );
endinterface

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, writing zero, then enters RUN and raises ready.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     clr_we,
    output logic [ADDRESS_WIDTH-1:0] clr_addr,
    output logic                     run,
    output logic                     ready
);

    rf_state_t                state;
    logic [ADDRESS_WIDTH-1:0] idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            idx   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    // Index holds at the last entry instead of wrapping.
                    if (idx == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= CLEAR;
                    idx   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        clr_we   = rst_n && (state == CLEAR);
        clr_addr = idx;
        run      = (state == RUN);
    end

endmodule

// File: rtl/reg_file_nport.sv
// N-read/1-write register file with optional hardwired zero entry, write bypass and clear-on-reset.
module reg_file_nport
    import reg_file_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned READ_PORTS    = DEF_READ_PORTS,
    parameter int unsigned ZERO_REG      = 1,
    parameter int unsigned BYPASS        = 1
) (
    input logic              clk,
    input logic              rst_n,
    reg_file_nport_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    logic [WORD_WIDTH-1:0]    mem [DEPTH];
    logic                     clr_we;
    logic [ADDRESS_WIDTH-1:0] clr_addr;
    logic                     run;
    logic                     ready;
    logic                     wr_en;
    logic [WORD_WIDTH-1:0]    rd_q [READ_PORTS];

    reg_file_clear_seq #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .run      (run),
        .ready    (ready)
    );

    always_comb begin
        wr_en = rst_n && run &&
                write_allowed(bus.WEN, bus.WA3 == '0, ZERO_REG != 0);
    end

    // Clear path owns the array until RUN; WEN is only honoured afterwards.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[bus.WA3] <= bus.WD3;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDRESS_WIDTH-1:0] ra;

        always_comb begin
            ra = bus.RA[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        end

        always_ff @(posedge clk) begin
            if (!rst_n || !run) begin
                rd_q[p] <= '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_q[p] <= '0;
            end else if ((BYPASS != 0) && wr_en && (bus.WA3 == ra)) begin
                rd_q[p] <= bus.WD3;
            end else begin
                rd_q[p] <= mem[ra];
            end
        end

        assign bus.RD[p*WORD_WIDTH +: WORD_WIDTH] = rd_q[p];
    end

    assign bus.READY = ready;

endmodule

// File: tb/tb_reg_file_nport.sv
// Directed plus randomized check of two register file configurations against an array model.
module tb_reg_file_nport;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Instance 0: 2 ports, zero reg, bypass. Instance 1: 4 ports, plain entry 0, no bypass.
    int zr [2] = '{1, 0};
    int bp [2] = '{1, 0};
    int np [2] = '{2, 4};

    logic [4:0]  ra  [2][4];
    logic [4:0]  wa  [2];
    logic [31:0] wd  [2];
    logic        wen [2];

    logic [31:0] mm      [2][32];
    int          highs   [2];
    logic [31:0] exp_rd  [2][4];
    logic        exp_rdy [2];

    reg_file_nport_if #(.WORD_WIDTH(32), .ADDRESS_WIDTH(5), .READ_PORTS(2)) if_a ();
    reg_file_nport_if #(.WORD_WIDTH(32), .ADDRESS_WIDTH(5), .READ_PORTS(4)) if_b ();

    assign if_a.RA  = {ra[0][1], ra[0][0]};
    assign if_a.WA3 = wa[0];
    assign if_a.WD3 = wd[0];
    assign if_a.WEN = wen[0];
    assign if_b.RA  = {ra[1][3], ra[1][2], ra[1][1], ra[1][0]};
    assign if_b.WA3 = wa[1];
    assign if_b.WD3 = wd[1];
    assign if_b.WEN = wen[1];

    reg_file_nport #(
        .WORD_WIDTH(32), .ADDRESS_WIDTH(5), .READ_PORTS(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    reg_file_nport #(
        .WORD_WIDTH(32), .ADDRESS_WIDTH(5), .READ_PORTS(4), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    function automatic logic [31:0] get_rd(input int i, input int p);
        logic [31:0] v;
        if (i == 0) v = if_a.RD[p*32 +: 32];
        else        v = if_b.RD[p*32 +: 32];
        return v;
    endfunction

    function automatic logic get_rdy(input int i);
        return (i == 0) ? if_a.READY : if_b.READY;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model of one edge: 32 high-reset edges clear everything, then RUN rules apply.
    task automatic model_edge(input int i);
        bit   running;
        logic eff;
        running = (highs[i] >= 32);
        for (int p = 0; p < 4; p++) exp_rd[i][p] = '0;
        if (!rst_n) begin
            highs[i]   = 0;
            exp_rdy[i] = 1'b0;
        end else if (!running) begin
            highs[i]++;
            exp_rdy[i] = (highs[i] >= 32);
            if (highs[i] == 32)
                for (int k = 0; k < 32; k++) mm[i][k] = '0;
        end else begin
            exp_rdy[i] = 1'b1;
            eff = wen[i] && !(zr[i] != 0 && wa[i] == 0);
            for (int p = 0; p < np[i]; p++) begin
                if (zr[i] != 0 && ra[i][p] == 0)               exp_rd[i][p] = '0;
                else if (bp[i] != 0 && eff && wa[i] == ra[i][p]) exp_rd[i][p] = wd[i];
                else                                            exp_rd[i][p] = mm[i][ra[i][p]];
            end
            if (eff) mm[i][wa[i]] = wd[i];
        end
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++) model_edge(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready_%0d", i), {31'd0, get_rdy(i)}, {31'd0, exp_rdy[i]});
            for (int p = 0; p < np[i]; p++)
                chk($sformatf("rd_%0d_%0d", i, p), get_rd(i, p), exp_rd[i][p]);
        end
    endtask

    task automatic set_w(input logic e, input logic [4:0] a, input logic [31:0] d);
        for (int i = 0; i < 2; i++) begin
            wen[i] = e;
            wa[i]  = a;
            wd[i]  = d;
        end
    endtask

    task automatic set_ra(input int p, input logic [4:0] a);
        for (int i = 0; i < 2; i++) ra[i][p] = a;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            highs[i] = 0;
            for (int p = 0; p < 4; p++) ra[i][p] = '0;
        end
        set_w(1'b0, 5'd0, 32'd0);
        @(negedge clk);

        rst_n = 1'b0;
        step();
        step();

        // Clear sequence with WEN asserted throughout: must be ignored.
        rst_n = 1'b1;
        set_w(1'b1, 5'd3, 32'h000000FF);
        for (int k = 0; k < 31; k++) step();
        chk("ready_low_edge31", {31'd0, if_a.READY}, 32'd0);
        step();
        chk("ready_high_edge32", {31'd0, if_a.READY}, 32'd1);
        set_w(1'b0, 5'd0, 32'd0);

        for (int k = 0; k < 32; k++) begin
            for (int p = 0; p < 4; p++) set_ra(p, 5'(k + p * 8));
            step();
        end
        set_ra(0, 5'd3);
        step();
        chk("entry3_after_clear", get_rd(1, 0), 32'h0);

        // Same-edge write/read of entry 5.
        set_w(1'b1, 5'd5, 32'hDEADBEEF);
        set_ra(0, 5'd5);
        step();
        chk("bypass_on", get_rd(0, 0), 32'hDEADBEEF);
        chk("bypass_off", get_rd(1, 0), 32'h0);
        set_w(1'b0, 5'd0, 32'd0);
        step();
        chk("bypass_off_next", get_rd(1, 0), 32'hDEADBEEF);

        // Entry 0 write.
        set_w(1'b1, 5'd0, 32'h12345678);
        step();
        set_w(1'b0, 5'd0, 32'd0);
        set_ra(0, 5'd0);
        set_ra(1, 5'd0);
        step();
        chk("zero_reg_p1", get_rd(0, 1), 32'h0);
        chk("plain_r0_p1", get_rd(1, 1), 32'h12345678);

        // Four-port distinct and repeated addresses.
        set_w(1'b1, 5'd1, 32'h11); step();
        set_w(1'b1, 5'd2, 32'h22); step();
        set_w(1'b1, 5'd3, 32'h33); step();
        set_w(1'b0, 5'd0, 32'd0);
        set_ra(0, 5'd1); set_ra(1, 5'd2); set_ra(2, 5'd3); set_ra(3, 5'd1);
        step();
        chk("four_port_p3", get_rd(1, 3), 32'h11);

        // Reset mid-run, then again mid-clear at index 10.
        set_w(1'b1, 5'd7, 32'hA5A5A5A5); step();
        set_w(1'b0, 5'd0, 32'd0);
        set_ra(0, 5'd7);
        step();
        chk("entry7_written", get_rd(0, 0), 32'hA5A5A5A5);
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        rst_n = 1'b0; step();
        chk("ready_in_reset", {31'd0, if_b.READY}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) step();
        step();
        chk("entry7_recleared", get_rd(0, 0), 32'h0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < 2; i++) begin
                wen[i] = $urandom_range(0, 1) != 0;
                wa[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                wd[i]  = $urandom;
                for (int p = 0; p < 4; p++)
                    ra[i][p] = ($urandom_range(0, 3) == 0) ? wa[i] : 5'($urandom_range(0, 31));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_nport.md
# reg_file_nport

Parametrised successor register file for the RISC-V core: N registered read ports, one write port, optional hardwired-zero entry 0, optional same-cycle write-to-read forwarding, and a post-reset clear sequencer that zeroes every entry before signalling ready. Sits between decode (read addresses) and writeback (write port). Read latency matches the existing one-cycle registered-read datapath.

## Interface
- WORD_WIDTH, 32, bits per register
- ADDRESS_WIDTH, 5, address bits; DEPTH = 2**ADDRESS_WIDTH
- READ_PORTS, 2, number of read ports (>=1)
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes
- BYPASS, 1, 1 = same-edge write forwarded to matching read port

- clk  in  1  clock, all activity on posedge
- rst_n  in  1  reset, synchronous, active-low
- RA  in  READ_PORTS*ADDRESS_WIDTH  read addresses, port p at [p*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- WA3  in  ADDRESS_WIDTH  write address
- WD3  in  WORD_WIDTH  write data
- WEN  in  1  write enable
- RD  out  READ_PORTS*WORD_WIDTH  registered read data, port p at [p*WORD_WIDTH +: WORD_WIDTH]
- READY  out  1  high once clear sequence complete

## Operation
- States: CLEAR, RUN. rst_n low at an edge: state <= CLEAR, clear index <= 0, RD <= 0, READY <= 0.
- CLEAR (rst_n high): each edge writes 0 to entry[index], index++. At edge where index == DEPTH-1: write 0, state <= RUN, READY <= 1. Takes exactly DEPTH edges; index never wraps.
- During CLEAR: WEN ignored, RD held at 0, READY 0.
- RUN: at each edge, if WEN and not (ZERO_REG and WA3 == 0) then entry[WA3] <= WD3.
- RUN read, each port p independently at each edge:
  - ZERO_REG and RA[p] == 0: RD[p] <= 0.
  - else BYPASS and effective write (as above) and WA3 == RA[p]: RD[p] <= WD3.
  - else RD[p] <= entry[RA[p]] (pre-edge contents).
- Multiple ports reading the same address all get identical data.
- ZERO_REG=0: entry 0 is an ordinary register.

## Timing
- Read latency 1: RA sampled at edge k, RD valid after edge k until edge k+1.
- Write visible: via RD after edge k if BYPASS=1 and RA matches at edge k; otherwise from read sampled at edge k+1.
- After rst_n rises at edge r (first edge sampling high), READY rises after edge r+DEPTH-1; first accepted write at edge r+DEPTH.
- rst_n low mid-CLEAR or mid-RUN: restarts sequence from index 0; array contents irrelevant until cleared.
- Reset values: RD = 0, READY = 0.

## Structure
- Package reg_file_pkg: state enum typedef (CLEAR, RUN), default width constants.
- Sub-module reg_file_clear_seq: state register, clear index counter, READY; outputs clear write enable/address to the array.
- Top instantiates array, write mux (clear vs. WEN path), generate loop over READ_PORTS for read/bypass/zero logic.

## Test plan
- Reset then rst_n high: READY low for 32 edges, high after edge 32; read all 32 entries -> 0x00000000 each.
- WEN=1 WA3=5 WD3=0xDEADBEEF, RA0=5 same edge: BYPASS=1 -> RD0=0xDEADBEEF next cycle; BYPASS=0 -> 0, then 0xDEADBEEF on following read.
- WEN=1 WA3=0 WD3=0x12345678, then RA0=RA1=0: ZERO_REG=1 -> both 0; ZERO_REG=0 -> both 0x12345678.
- WEN during CLEAR (WA3=3 WD3=0xFF): after READY, reading 3 -> 0.
- Write 0xA5A5A5A5 to entry 7, READY high; pulse rst_n low 1 cycle mid-run and mid-clear (index 10): RD 0, READY 0, full 32-edge clear repeats, entry 7 -> 0.
- READ_PORTS=4, distinct addresses 1,2,3,1 after writing 0x11,0x22,0x33: RD = 0x11,0x22,0x33,0x11 one cycle later.
